arm_mainfsm: RTL and testbench
==============================

// Module: arm_mainfsm
// PURPOSE
//  Multicycle ARM main control FSM; sits directly upstream of the flopenr-based datapath registers.
//  Sequences each instruction through fetch/decode/execute/writeback states.
//  Produces the per-cycle enables (irwrite, nextpc, regw, memw, branch) and the datapath mux selects.
//  Condition gating of regw/memw/nextpc is done downstream in condlogic, not here.
// PARAMETERS
//  none (state encoding internal; 4-bit binary)
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  asynchronous, active-high; forces FETCH
//  op         in   2  instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 illegal
//  funct      in   6  instr[25:20]; funct[5]=I (immediate), funct[0]=L (load)
//  irwrite    out  1  enable for instruction register flopenr
//  nextpc     out  1  PC update request (to condlogic / PC flopenr)
//  regw       out  1  register-file write request
//  memw       out  1  data-memory write request
//  branch     out  1  branch instruction marker
//  aluop      out  1  1 = ALU decoder uses funct; 0 = force ADD
//  adrsrc     out  1  memory address select: 0 PC, 1 Result
//  alusrca    out  1  ALU A select: 0 RD1, 1 PC
//  alusrcb    out  2  ALU B select: 00 RD2, 01 ExtImm, 10 const 4
//  resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//  illegal    out  1  high for the one cycle spent in ILLEGAL
// BEHAVIOUR
//  Moore machine; outputs purely from the registered state; unlisted outputs = 0 (no X).
//  Per-state outputs:
//   FETCH    adrsrc=0 alusrca=1 alusrcb=10 resultsrc=10 irwrite=1 nextpc=1
//   DECODE   alusrca=1 alusrcb=10 resultsrc=10
//   MEMADR   alusrca=0 alusrcb=01
//   MEMRD    adrsrc=1 resultsrc=00
//   MEMWB    resultsrc=01 regw=1
//   MEMWR    adrsrc=1 resultsrc=00 memw=1
//   EXECR    alusrca=0 alusrcb=00 aluop=1
//   EXECI    alusrca=0 alusrcb=01 aluop=1
//   ALUWB    resultsrc=00 regw=1
//   BRANCH   alusrca=0 alusrcb=01 resultsrc=10 branch=1
//   ILLEGAL  illegal=1, all else 0
//  Transitions (one per clk):
//   FETCH->DECODE
//   DECODE: op=01->MEMADR; op=00&!funct[5]->EXECR; op=00&funct[5]->EXECI;
//           op=10->BRANCH; op=11->ILLEGAL
//   MEMADR: funct[0]=1->MEMRD, else MEMWR
//   MEMRD->MEMWB; EXECR/EXECI->ALUWB
//   MEMWB, MEMWR, ALUWB, BRANCH, ILLEGAL -> FETCH
//   unused encodings -> FETCH (no lockup)
//  Latency: LDR 5, STR 4, DP 4, B 3, illegal 3 cycles, FETCH to next FETCH.
//  op/funct sampled only in DECODE and MEMADR; changes elsewhere have no effect.
//  Reset: state<=FETCH immediately (async), so FETCH outputs (irwrite=1, nextpc=1) are visible
//   while reset is high; downstream flopenr regs are held in reset, so these are harmless.
//  Reset mid-instruction: aborts at once, no further regw/memw pulse; first post-reset edge -> DECODE.
//  Exactly one of regw/memw/irwrite/branch/illegal is high in any state (or none).
// TESTING
//  1. Reset high, clk free-running -> state FETCH, irwrite=1, nextpc=1; deassert -> DECODE on next edge.
//  2. op=01 funct=6'b011001 (LDR) -> FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regw=1 only in cycle 5, resultsrc=01.
//  3. op=01 funct=6'b011000 (STR) -> 4-cycle path; memw=1 only in MEMWR with adrsrc=1; regw never high.
//  4. op=00 funct=6'b101000 (ADD imm) -> EXECI (alusrcb=01, aluop=1), then ALUWB; funct[5]=0 -> EXECR (alusrcb=00).
//  5. op=10 -> BRANCH 1 cycle (branch=1, alusrcb=01), then FETCH; op=11 -> illegal=1 one cycle, no regw/memw.
//  6. Assert reset while in MEMWR/ALUWB -> same-cycle return to FETCH, memw/regw drop with no extra pulse.

Source files
------------

// File: rtl/arm_mainfsm.sv
// Multicycle ARM main control FSM.
// Steps each instruction through fetch, decode, execute and writeback states.
// Every output is decoded from the registered state only (Moore machine).
// Condition gating of regw/memw/nextpc is done downstream, not here.
module arm_mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    output logic       irwrite,
    output logic       nextpc,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       aluop,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ILLEGAL = 4'd10
    } state_e;

    state_e r_state;
    state_e w_next;

    // State register; reset forces FETCH immediately and aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; op/funct are only consulted in DECODE and MEMADR.
    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: w_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ILLEGAL: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decode; everything not listed for a state stays 0.
    always_comb begin
        irwrite   = 1'b0;
        nextpc    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        aluop     = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        illegal   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                adrsrc    = 1'b0;
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = 1'b1;
                nextpc    = 1'b1;
            end
            S_DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            S_MEMADR: begin
                alusrca   = 1'b0;
                alusrcb   = 2'b01;
            end
            S_MEMRD: begin
                adrsrc    = 1'b1;
                resultsrc = 2'b00;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regw      = 1'b1;
            end
            S_MEMWR: begin
                adrsrc    = 1'b1;
                resultsrc = 2'b00;
                memw      = 1'b1;
            end
            S_EXECR: begin
                alusrca   = 1'b0;
                alusrcb   = 2'b00;
                aluop     = 1'b1;
            end
            S_EXECI: begin
                alusrca   = 1'b0;
                alusrcb   = 2'b01;
                aluop     = 1'b1;
            end
            S_ALUWB: begin
                resultsrc = 2'b00;
                regw      = 1'b1;
            end
            S_BRANCH: begin
                alusrca   = 1'b0;
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                branch    = 1'b1;
            end
            S_ILLEGAL: begin
                illegal   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arm_mainfsm.sv
// Scoreboard bench for arm_mainfsm: a driver issues instructions and pushes the
// expected per-cycle control vector; a monitor pops and compares each cycle.
module tb_arm_mainfsm;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       irwrite, nextpc, regw, memw, branch, aluop, adrsrc, alusrca, illegal;
    logic [1:0] alusrcb, resultsrc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Phase names used by the reference model (independent of the DUT encoding).
    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_XR, P_XI, P_AWB, P_B, P_ILL} phase_e;

    typedef struct {
        logic [12:0] vec;
        string       name;
    } exp_t;

    exp_t q[$];

    arm_mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .irwrite   (irwrite),
        .nextpc    (nextpc),
        .regw      (regw),
        .memw      (memw),
        .branch    (branch),
        .aluop     (aluop),
        .adrsrc    (adrsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {irwrite,nextpc,regw,memw,branch,illegal,aluop,adrsrc,alusrca,alusrcb,resultsrc}
    function automatic logic [12:0] mk(input logic irw, input logic npc, input logic rw,
                                       input logic mw, input logic br, input logic il,
                                       input logic ao, input logic as, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] rs);
        return {irw, npc, rw, mw, br, il, ao, as, sa, sb, rs};
    endfunction

    // Per-phase control values taken from the behavioural table.
    function automatic logic [12:0] phase_vec(input phase_e p);
        case (p)
            P_F:     return mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10);
            P_D:     return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10);
            P_MA:    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00);
            P_MR:    return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
            P_MWB:   return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01);
            P_MW:    return mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00);
            P_XR:    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
            P_XI:    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00);
            P_AWB:   return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
            P_B:     return mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b10);
            default: return mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
        endcase
    endfunction

    // Instruction class -> list of phases from FETCH up to (not including) the next FETCH.
    function automatic void build_seq(input logic [1:0] o, input logic [5:0] f, output phase_e s[$]);
        s = {};
        case (o)
            2'b01:   s = f[0] ? '{P_F, P_D, P_MA, P_MR, P_MWB} : '{P_F, P_D, P_MA, P_MW};
            2'b00:   s = f[5] ? '{P_F, P_D, P_XI, P_AWB} : '{P_F, P_D, P_XR, P_AWB};
            2'b10:   s = '{P_F, P_D, P_B};
            default: s = '{P_F, P_D, P_ILL};
        endcase
    endfunction

    function automatic int expected_len(input logic [1:0] o, input logic [5:0] f);
        case (o)
            2'b01:   return f[0] ? 5 : 4;
            2'b00:   return 4;
            default: return 3;
        endcase
    endfunction

    task automatic push_exp(input phase_e p, input string nm);
        exp_t e;
        e.vec  = phase_vec(p);
        e.name = nm;
        q.push_back(e);
    endtask

    // One instruction; abort_at >= 1 asserts reset in that cycle instead of its normal phase.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int abort_at);
        phase_e s[$];
        build_seq(o, f, s);
        n_checks++;
        if (s.size() != expected_len(o, f)) begin
            n_errors++;
            $display("FAIL latency op=%b funct=%b got=%0d want=%0d", o, f, s.size(), expected_len(o, f));
        end
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                reset = 1'b1;
                push_exp(P_F, "abort");
                op    = 2'($urandom);
                funct = 6'($urandom);
                return;
            end
            push_exp(s[k], s[k].name());
            if (reset) reset = 1'b0;
            if (s[k] == P_D || s[k] == P_MA) begin
                op    = o;
                funct = f;
            end else begin
                op    = 2'($urandom);
                funct = 6'($urandom);
            end
        end
    endtask

    // Monitor: compares DUT outputs against the oldest expectation, away from the active edge.
    initial begin
        logic [12:0] got;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {irwrite, nextpc, regw, memw, branch, illegal, aluop, adrsrc, alusrca, alusrcb, resultsrc};
                n_checks++;
                if (got !== e.vec) begin
                    n_errors++;
                    $display("FAIL %s t=%0t got=%b want=%b", e.name, $time, got, e.vec);
                end
            end
        end
    end

    // Driver: directed instructions, reset aborts, then random traffic.
    initial begin
        int n;
        reset = 1'b1;
        op    = '0;
        funct = '0;
        // Outputs held at FETCH while reset is high, regardless of inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push_exp(P_F, "reset_hold");
            op    = 2'($urandom);
            funct = 6'($urandom);
        end
        run_instr(2'b01, 6'b011001, -1);   // LDR
        run_instr(2'b01, 6'b011000, -1);   // STR
        run_instr(2'b00, 6'b101000, -1);   // ADD immediate
        run_instr(2'b00, 6'b001000, -1);   // ADD register
        run_instr(2'b10, 6'b100000, -1);   // B
        run_instr(2'b11, 6'b111111, -1);   // illegal
        run_instr(2'b01, 6'b011000, 3);    // reset in MEMWR
        run_instr(2'b00, 6'b101000, 3);    // reset in ALUWB
        run_instr(2'b01, 6'b011001, 2);    // reset in MEMADR
        for (int i = 0; i < 200; i++) begin
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : -1;
            run_instr(2'($urandom), 6'($urandom), n);
        end
        // Closing FETCH after the last instruction.
        @(posedge clk);
        #1;
        push_exp(P_F, "final_fetch");
        if (reset) reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
